// File: rtl/ordenador_n_if.sv
// ordenador_n_if: load/sort/read bus of the ordenador_n sorter.
// master = the side that writes data, starts runs and reads results;
// slave  = the sorter itself.
interface ordenador_n_if #(
  parameter int W  = 8,
  parameter int AW = 4
);
  logic          start;
  logic          we;
  logic [AW-1:0] wa;
  logic [W-1:0]  entrada;
  logic          descending;
  logic [AW-1:0] ra;
  logic [W-1:0]  saida;
  logic          idle;
  logic          done;

  modport master (
    output start, we, wa, entrada, descending, ra,
    input  saida, idle, done
  );

  modport slave (
    input  start, we, wa, entrada, descending, ra,
    output saida, idle, done
  );
endinterface

// File: rtl/ordenador_n.sv
// ordenador_n: N-element odd-even transposition sorter.
// Elements are written into an input memory, a start copies them into a
// working array that goes through one compare-exchange phase per clock,
// and the final array is committed to an output memory read through ra.
// Optional feature macro: ORDENADOR_EARLY_EXIT_EN -- finish the run as soon
// as two consecutive phases made no swap (the array is then sorted).
//
// state   | meaning
// --------+-----------------------------------------------------------
// READING | accepting writes, output memory stable, waiting for start
// SORTING | one odd-even phase per clock, writes and start ignored
module ordenador_n #(
  parameter int N  = 9,
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clock,
  input  logic         reset,
  ordenador_n_if.slave bus
);

  localparam int PW = $clog2(N);

  typedef enum logic {
    READING = 1'b0,
    SORTING = 1'b1
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [W-1:0]  in_mem  [N];
  logic [W-1:0]  work    [N];
  logic [W-1:0]  out_mem [N];
  logic [W-1:0]  stepped [N];
  logic [PW-1:0] phase;
  logic          mode;
  logic          done_q;
  logic          load;
  logic          step;
  logic          commit;
  logic          last_phase;
  logic [W-1:0]  saida_c;
`ifdef ORDENADOR_EARLY_EXIT_EN
  logic          swap_any;
  logic          prev_quiet;
`endif

  // One compare-exchange phase on the working array; pairs are disjoint,
  // so every compare reads the unmodified array. Equal values stay put.
  always_comb begin
    for (int i = 0; i < N; i++) stepped[i] = work[i];
`ifdef ORDENADOR_EARLY_EXIT_EN
    swap_any = 1'b0;
`endif
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == phase[0]) begin
        if (mode ? (work[i] < work[i+1]) : (work[i] > work[i+1])) begin
          stepped[i]   = work[i+1];
          stepped[i+1] = work[i];
`ifdef ORDENADOR_EARLY_EXIT_EN
          swap_any = 1'b1;
`endif
        end
      end
    end
  end

  // Run ends after phase N-1, or earlier once two phases in a row were quiet.
  always_comb begin
    last_phase = (phase == PW'(N - 1));
`ifdef ORDENADOR_EARLY_EXIT_EN
    if ((phase != '0) && !swap_any && prev_quiet) last_phase = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= READING;
    else       state <= state_n;
  end

  // Next-state and control strobes.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state)
      READING: begin
        if (bus.start) begin
          state_n = SORTING;
          load    = 1'b1;
        end
      end
      SORTING: begin
        step = 1'b1;
        if (last_phase) begin
          commit  = 1'b1;
          state_n = READING;
        end
      end
      default: state_n = READING;
    endcase
  end

  // Memories, working array, phase counter, latched mode and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        in_mem[i]  <= '0;
        work[i]    <= '0;
        out_mem[i] <= '0;
      end
      phase      <= '0;
      mode       <= 1'b0;
      done_q     <= 1'b0;
`ifdef ORDENADOR_EARLY_EXIT_EN
      prev_quiet <= 1'b0;
`endif
    end else begin
      done_q <= commit;
      if (state == READING) begin
        for (int i = 0; i < N; i++)
          if (bus.we && (bus.wa == AW'(i))) in_mem[i] <= bus.entrada;
      end
      if (load) begin
        // A write landing on the start edge goes straight into the run.
        for (int i = 0; i < N; i++)
          work[i] <= (bus.we && (bus.wa == AW'(i))) ? bus.entrada : in_mem[i];
        mode  <= bus.descending;
        phase <= '0;
`ifdef ORDENADOR_EARLY_EXIT_EN
        prev_quiet <= 1'b0;
`endif
      end else if (step) begin
        for (int i = 0; i < N; i++) work[i] <= stepped[i];
        if (!commit) phase <= phase + PW'(1);
`ifdef ORDENADOR_EARLY_EXIT_EN
        prev_quiet <= !swap_any;
`endif
      end
      if (commit) begin
        for (int i = 0; i < N; i++) out_mem[i] <= stepped[i];
      end
    end
  end

  // Output read port; addresses at or above N read as zero.
  always_comb begin
    saida_c = '0;
    for (int i = 0; i < N; i++)
      if (bus.ra == AW'(i)) saida_c = out_mem[i];
  end

  assign bus.saida = saida_c;
  assign bus.idle  = (state == READING);
  assign bus.done  = done_q;

endmodule
